// File: rtl/fp_pipe.sv
// -----------------------------------------------------------------------------
// fp_pipe : parametrised elastic bit-vector filter pipeline.
//
// LANES bit-vector lanes move through STAGES register stages. On its way into
// stage s each beat is first permuted (lane l takes the vector from source lane
// sel[s][l]). Each lane then goes through a pairwise bitwise filter op[s][l]
// with operands a = own permuted lane and b = permuted partner lane (l^1).
// Stages advance under valid/ready flow control with bubble collapsing.
// Configuration is written at runtime one (stage, lane) entry at a time.
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active low
//   in_data    input beat, lane l at [l*BIT_VEC_SIZE +: BIT_VEC_SIZE]
//   in_valid   input beat valid
//   in_ready   pipeline accepts a beat this cycle (combinational)
//   out_data   result beat (last stage register), same lane packing
//   out_valid  result beat valid (last stage valid)
//   out_ready  consumer accepts the result beat
//   cfg_we     configuration write strobe
//   cfg_stage  target stage of the write
//   cfg_lane   target lane of the write
//   cfg_sel    permutation source lane for the target lane
//   cfg_op     filter opcode for the target lane
//   flush      synchronous clear of all stage valids
//   occupancy  registered count of valid stage registers
// -----------------------------------------------------------------------------
module fp_pipe #(
    parameter int LANES        = 4,
    parameter int STAGES       = 8,
    parameter int BIT_VEC_SIZE = 128,
    parameter int LANE_LOG     = $clog2(LANES),
    parameter int STAGE_LOG    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [LANES*BIT_VEC_SIZE-1:0]   in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [LANES*BIT_VEC_SIZE-1:0]   out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  logic                            cfg_we,
    input  logic [STAGE_LOG-1:0]            cfg_stage,
    input  logic [LANE_LOG-1:0]             cfg_lane,
    input  logic [LANE_LOG-1:0]             cfg_sel,
    input  logic [2:0]                      cfg_op,
    input  logic                            flush,
    output logic [$clog2(STAGES+1)-1:0]     occupancy
);

    localparam int OCC_W  = $clog2(STAGES + 1);
    localparam int BEAT_W = LANES * BIT_VEC_SIZE;

    localparam logic [STAGE_LOG:0] STAGE_LIMIT = (STAGE_LOG + 1)'(STAGES);
    localparam logic [LANE_LOG:0]  LANE_LIMIT  = (LANE_LOG + 1)'(LANES);

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_ANDN = 3'd4;
    localparam logic [2:0] OP_ZERO = 3'd5;
    localparam logic [2:0] OP_ONES = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    typedef logic [BIT_VEC_SIZE-1:0] vec_t;
    typedef logic [LANE_LOG-1:0]     lane_idx_t;

    // Pairwise bitwise filter applied to one lane.
    function automatic vec_t filter_op(input logic [2:0] op, input vec_t a, input vec_t b);
        vec_t r;
        case (op)
            OP_PASS: r = a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ANDN: r = a & ~b;
            OP_ZERO: r = {BIT_VEC_SIZE{1'b0}};
            OP_ONES: r = {BIT_VEC_SIZE{1'b1}};
            OP_NOT:  r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    // Population count of the stage valid vector.
    function automatic logic [OCC_W-1:0] count_valid(input logic [STAGES-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = {OCC_W{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

    // Configuration and pipeline state
    lane_idx_t                      sel_r [STAGES][LANES];
    logic [2:0]                     op_r  [STAGES][LANES];
    logic [STAGES-1:0][BEAT_W-1:0]  data_r;
    logic [STAGES-1:0]              valid_r;
    logic [OCC_W-1:0]               occ_r;

    // Combinational flow-control and datapath signals
    logic [STAGES-1:0]              ready_s;
    logic [STAGES-1:0]              valid_nxt_s;
    logic [STAGES:0]                up_valid_s;
    logic [STAGES-1:0][BEAT_W-1:0]  stage_res_s;
    logic                           in_fire_s;
    logic                           cfg_ok_s;

    assign in_ready  = ready_s[0] & ~flush;
    assign in_fire_s = in_valid & in_ready;

    // Valid presented to each stage: stage 0 sees the accepted input beat,
    // stage s sees the valid of stage s-1.
    assign up_valid_s = {valid_r, in_fire_s};

    assign out_data  = data_r[STAGES-1];
    assign out_valid = valid_r[STAGES-1];
    assign occupancy = occ_r;

    // Ready chain: a stage can load if it is empty or everything downstream
    // can move, which collapses bubbles even while the output is stalled.
    always_comb begin
        logic ready_acc;
        ready_s   = {STAGES{1'b0}};
        ready_acc = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            ready_acc  = ready_acc | ~valid_r[s];
            ready_s[s] = ready_acc;
        end
    end

    // Next stage valids; flush wins over any advance.
    always_comb begin
        valid_nxt_s = valid_r;
        if (flush) begin
            valid_nxt_s = {STAGES{1'b0}};
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (ready_s[s]) begin
                    valid_nxt_s[s] = up_valid_s[s];
                end else begin
                    valid_nxt_s[s] = valid_r[s];
                end
            end
        end
    end

    // A configuration write is only taken if every index names a real entry,
    // so a lane select can never point outside the beat.
    always_comb begin
        cfg_ok_s = 1'b0;
        if (({1'b0, cfg_stage} < STAGE_LIMIT) &&
            ({1'b0, cfg_lane}  < LANE_LIMIT)  &&
            ({1'b0, cfg_sel}   < LANE_LIMIT)) begin
            cfg_ok_s = 1'b1;
        end else begin
            cfg_ok_s = 1'b0;
        end
    end

    for (genvar gs = 0; gs < STAGES; gs++) begin : g_stage
        logic [BEAT_W-1:0] stage_in_s;
        vec_t              lane_in_s [LANES];
        vec_t              perm_s    [LANES];
        logic [BEAT_W-1:0] result_s;

        if (gs == 0) begin : g_first
            assign stage_in_s = in_data;
        end else begin : g_rest
            assign stage_in_s = data_r[gs-1];
        end

        // Permute the incoming lanes, then apply the per-lane pairwise filter.
        always_comb begin
            lane_in_s = '{default: {BIT_VEC_SIZE{1'b0}}};
            perm_s    = '{default: {BIT_VEC_SIZE{1'b0}}};
            result_s  = {BEAT_W{1'b0}};
            for (int l = 0; l < LANES; l++) begin
                lane_in_s[l] = stage_in_s[l*BIT_VEC_SIZE +: BIT_VEC_SIZE];
            end
            for (int l = 0; l < LANES; l++) begin
                perm_s[l] = lane_in_s[sel_r[gs][l]];
            end
            for (int l = 0; l < LANES; l++) begin
                result_s[l*BIT_VEC_SIZE +: BIT_VEC_SIZE] =
                    filter_op(op_r[gs][l], perm_s[l], perm_s[l ^ 32'sd1]);
            end
        end

        assign stage_res_s[gs] = result_s;
    end

    // Stage registers, valids and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {STAGES{1'b0}};
            data_r  <= {(STAGES*BEAT_W){1'b0}};
            occ_r   <= {OCC_W{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            occ_r   <= count_valid(valid_nxt_s);
            for (int s = 0; s < STAGES; s++) begin
                if (ready_s[s] && !flush) begin
                    data_r[s] <= stage_res_s[s];
                end else begin
                    data_r[s] <= data_r[s];
                end
            end
        end
    end

    // Configuration table; reset restores the identity pipeline, flush leaves
    // it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    sel_r[s][l] <= LANE_LOG'(l);
                    op_r[s][l]  <= OP_PASS;
                end
            end
        end else if (cfg_we && cfg_ok_s) begin
            sel_r[cfg_stage][cfg_lane] <= cfg_sel;
            op_r[cfg_stage][cfg_lane]  <= cfg_op;
        end else begin
            sel_r <= sel_r;
            op_r  <= op_r;
        end
    end

endmodule

// File: tb/tb_fp_pipe.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fp_pipe (LANES=4, STAGES=3, BIT_VEC_SIZE=8).
// Expected beats come from a lane-level reference model evaluated at the
// moment a beat is accepted; occupancy and in_ready are predicted from the
// number of beats in flight.
// -----------------------------------------------------------------------------
module tb_fp_pipe;

    localparam int L = 4;
    localparam int S = 3;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [L*W-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [L*W-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          cfg_we;
    logic [1:0]    cfg_stage;
    logic [1:0]    cfg_lane;
    logic [1:0]    cfg_sel;
    logic [2:0]    cfg_op;
    logic          flush;
    logic [1:0]    occupancy;

    fp_pipe #(.LANES(L), .STAGES(S), .BIT_VEC_SIZE(W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_lane(cfg_lane),
        .cfg_sel(cfg_sel), .cfg_op(cfg_op), .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int             m_sel [S][L];
    int             m_op  [S][L];
    logic [L*W-1:0] exp_q [$];
    logic [L*W-1:0] got_q [$];
    int             inflight;

    // observations of the last tick
    logic           obs_in_ready, obs_out_valid, fire_in, fire_out;
    logic [L*W-1:0] obs_out_data;
    int             pre_inflight;
    logic           pre_out_ready, pre_flush;

    function automatic logic [W-1:0] ref_op(int op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            0: return a;
            1: return a & b;
            2: return a | b;
            3: return a ^ b;
            4: return a & ~b;
            5: return 8'h00;
            6: return 8'hFF;
            7: return ~a;
            default: return 8'hxx;
        endcase
    endfunction

    function automatic logic [L*W-1:0] ref_pipe(logic [L*W-1:0] x);
        logic [W-1:0] v [L];
        logic [W-1:0] p [L];
        logic [L*W-1:0] r;
        for (int l = 0; l < L; l++) v[l] = x[l*W +: W];
        for (int s = 0; s < S; s++) begin
            for (int l = 0; l < L; l++) p[l] = v[m_sel[s][l]];
            for (int l = 0; l < L; l++) v[l] = ref_op(m_op[s][l], p[l], p[l ^ 1]);
        end
        for (int l = 0; l < L; l++) r[l*W +: W] = v[l];
        return r;
    endfunction

    task automatic model_identity();
        for (int s = 0; s < S; s++)
            for (int l = 0; l < L; l++) begin
                m_sel[s][l] = l;
                m_op[s][l]  = 0;
            end
    endtask

    // One clock: sample at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        pre_inflight  = inflight;
        pre_out_ready = out_ready;
        pre_flush     = flush;
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        obs_out_data  = out_data;
        fire_in       = in_valid && in_ready;
        fire_out      = out_valid && out_ready;
        if (fire_in)  exp_q.push_back(ref_pipe(in_data));
        if (fire_out) got_q.push_back(out_data);
        @(posedge clk);
        #1;
        if (pre_flush) begin
            inflight = 0;
            while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        end else begin
            inflight = inflight + int'(fire_in) - int'(fire_out);
        end
        if (cfg_we && cfg_stage < 2'(S)) begin
            m_sel[cfg_stage][cfg_lane] = int'(cfg_sel);
            m_op[cfg_stage][cfg_lane]  = int'(cfg_op);
        end
    endtask

    task automatic cfg_write(int st, int ln, int sl, int op);
        cfg_we = 1'b1; cfg_stage = 2'(st); cfg_lane = 2'(ln); cfg_sel = 2'(sl); cfg_op = 3'(op);
        tick();
        cfg_we = 1'b0;
    endtask

    // Send one beat into an idle pipeline and report its result and latency.
    task automatic send_one(input logic [L*W-1:0] d, output logic [L*W-1:0] q, output int lat);
        in_data = d; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = -1; q = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (obs_out_valid && lat < 0) begin
                lat = k; q = obs_out_data;
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0; flush = 1'b0;
        in_data = '0; cfg_stage = '0; cfg_lane = '0; cfg_sel = '0; cfg_op = '0;
        inflight = 0; model_identity();
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        @(posedge clk); #1 rst = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_identity();
        logic [L*W-1:0] q; int lat;
        send_one({8'h55, 8'hAA, 8'hF0, 8'h0F}, q, lat);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL identity_latency got %0d want 3", lat); end
        n_cmp++; if (q !== {8'h55, 8'hAA, 8'hF0, 8'h0F}) begin n_err++; $display("FAIL identity_data got %h want 55aaf00f", q); end
    endtask

    task automatic test_pairwise();
        logic [L*W-1:0] q; int lat;
        cfg_write(0, 0, 0, 1);
        cfg_write(0, 2, 2, 3);
        send_one({8'h55, 8'hAA, 8'hF0, 8'h0F}, q, lat);
        n_cmp++; if (q !== {8'h55, 8'hFF, 8'hF0, 8'h00} || lat !== 3) begin
            n_err++; $display("FAIL pairwise_data got %h lat %0d want 55fff000 lat 3", q, lat);
        end
        cfg_write(0, 0, 0, 0);
        cfg_write(0, 2, 2, 0);
    endtask

    task automatic test_permutation();
        logic [L*W-1:0] q; int lat;
        cfg_write(1, 0, 1, 0);
        cfg_write(1, 1, 0, 0);
        send_one({8'h44, 8'h33, 8'h22, 8'h11}, q, lat);
        n_cmp++; if (q !== {8'h44, 8'h33, 8'h11, 8'h22}) begin
            n_err++; $display("FAIL permutation_data got %h want 44331122", q);
        end
        cfg_write(1, 0, 0, 0);
        cfg_write(1, 1, 1, 0);
    endtask

    task automatic test_backpressure();
        int next = 1; int maxocc = 0; logic stall_prev = 1'b0; logic [L*W-1:0] prev_data = '0;
        logic saw_block = 1'b0;
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < 60 && got_q.size() < 10; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            in_valid  = (next <= 10);
            in_data   = 32'(next);
            tick();
            n_cmp++; if (obs_in_ready !== (!pre_flush && (pre_out_ready || pre_inflight < S))) begin
                n_err++; $display("FAIL bp_in_ready cyc %0d got %0b inflight %0d", c, obs_in_ready, pre_inflight);
            end
            n_cmp++; if (occupancy !== 2'(inflight)) begin
                n_err++; $display("FAIL bp_occupancy cyc %0d got %0d want %0d", c, occupancy, inflight);
            end
            if (stall_prev) begin
                n_cmp++; if ({obs_out_valid, obs_out_data} !== {1'b1, prev_data}) begin
                    n_err++; $display("FAIL bp_stable cyc %0d got %b/%h want 1/%h", c, obs_out_valid, obs_out_data, prev_data);
                end
            end
            stall_prev = obs_out_valid && !pre_out_ready;
            prev_data  = obs_out_data;
            if (fire_in) next++;
            if (!obs_in_ready && pre_inflight == S) saw_block = 1'b1;
            if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
        end
        n_cmp++; if (maxocc !== 3) begin n_err++; $display("FAIL bp_max_occupancy got %0d want 3", maxocc); end
        n_cmp++; if (saw_block !== 1'b1) begin n_err++; $display("FAIL bp_full_block got %0b want 1", saw_block); end
        n_cmp++; if (got_q.size() !== 10) begin n_err++; $display("FAIL bp_count got %0d want 10", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 10; i++) begin
            n_cmp++; if (got_q[i] !== 32'(i + 1)) begin
                n_err++; $display("FAIL bp_order idx %0d got %h want %h", i, got_q[i], 32'(i + 1));
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_bubble();
        int sent = 0; int maxocc = 0;
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < 60 && got_q.size() < 6; c++) begin
            in_valid  = (c % 2 == 0) && (sent < 6);
            in_data   = $urandom;
            out_ready = !(c >= 8 && c <= 11);
            tick();
            if (fire_in) sent++;
            n_cmp++; if (occupancy !== 2'(inflight)) begin
                n_err++; $display("FAIL bubble_occupancy cyc %0d got %0d want %0d", c, occupancy, inflight);
            end
            if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
        end
        n_cmp++; if (maxocc !== 3) begin n_err++; $display("FAIL bubble_max_occupancy got %0d want 3", maxocc); end
        n_cmp++; if (got_q.size() !== 6 || exp_q.size() !== 6) begin
            n_err++; $display("FAIL bubble_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL bubble_order idx %0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_flush_reset();
        logic [L*W-1:0] q, x, want; int lat; int leaks = 0;
        cfg_write(2, 3, 3, 7);
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin in_data = $urandom; tick(); end
        n_cmp++; if (occupancy !== 2'd3) begin n_err++; $display("FAIL flush_prefill got %0d want 3", occupancy); end
        flush = 1'b1; in_data = $urandom;
        cfg_we = 1'b1; cfg_stage = 2'd1; cfg_lane = 2'd1; cfg_sel = 2'd1; cfg_op = 3'd6;
        tick();
        n_cmp++; if (obs_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %0b want 0", obs_in_ready); end
        flush = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occupancy got %0d want 0", occupancy); end
        for (int i = 0; i < 4; i++) begin tick(); if (obs_out_valid) leaks++; end
        n_cmp++; if (leaks !== 0) begin n_err++; $display("FAIL flush_out_valid got %0d beats want 0", leaks); end
        exp_q.delete(); got_q.delete();
        x = $urandom;
        want = {~x[31:24], x[23:16], 8'hFF, x[7:0]};
        send_one(x, q, lat);
        n_cmp++; if (q !== want) begin n_err++; $display("FAIL flush_config_kept got %h want %h", q, want); end
        // asynchronous reset with beats in flight
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin in_data = $urandom; tick(); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid got %0b want 1", out_valid); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({out_valid, out_data, occupancy} !== {1'b0, 32'h0, 2'd0}) begin
            n_err++; $display("FAIL midrst_clear got %b/%h/%0d want 0/0/0", out_valid, out_data, occupancy);
        end
        in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        inflight = 0; model_identity(); exp_q.delete(); got_q.delete();
        x = $urandom;
        send_one(x, q, lat);
        n_cmp++; if (q !== x || lat !== 3) begin
            n_err++; $display("FAIL midrst_identity got %h lat %0d want %h lat 3", q, lat, x);
        end
    endtask

    task automatic test_random();
        cfg_write(3, 0, 1, 5);
        for (int i = 0; i < 6; i++)
            cfg_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_data   = $urandom;
            tick();
            n_cmp++; if (obs_in_ready !== (pre_out_ready || pre_inflight < S)) begin
                n_err++; $display("FAIL rnd_in_ready cyc %0d got %0b inflight %0d", c, obs_in_ready, pre_inflight);
            end
            n_cmp++; if (occupancy !== 2'(inflight)) begin
                n_err++; $display("FAIL rnd_occupancy cyc %0d got %0d want %0d", c, occupancy, inflight);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && inflight > 0; c++) tick();
        n_cmp++; if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL rnd_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rnd_data idx %0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_pairwise();
        test_permutation();
        test_backpressure();
        test_bubble();
        test_flush_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_pipe.md
Name: fp_pipe

Overview:
- Parametrised elastic filter pipeline. Successor to the fixed INPUTS/STAGES filter pipeline.
- LANES bit-vector lanes pass through STAGES stages. Each stage applies a per-lane permutation followed by a pairwise bitwise filter op, then a register.
- Adds valid/ready flow control with bubble collapsing, a runtime configuration write port, synchronous flush and an occupancy count.
- Sits between the bit-vector producer and the result collector.

Parameters:
- LANES, 4, number of lanes; even, at least 2.
- STAGES, 8, number of pipeline stages; at least 1.
- BIT_VEC_SIZE, 128, width of each lane vector.
- LANE_LOG, $clog2(LANES), lane index width.
- STAGE_LOG, $clog2(STAGES) (minimum 1), stage index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- in_data  in  LANES*BIT_VEC_SIZE  lane l occupies [l*BIT_VEC_SIZE +: BIT_VEC_SIZE].
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline accepts a beat this cycle.
- out_data  out  LANES*BIT_VEC_SIZE  result beat; same lane packing as in_data.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result beat.
- cfg_we  in  1  configuration write strobe.
- cfg_stage  in  STAGE_LOG  target stage.
- cfg_lane  in  LANE_LOG  target lane.
- cfg_sel  in  LANE_LOG  source lane for the permutation.
- cfg_op  in  3  filter opcode.
- flush  in  1  synchronous pipeline clear.
- occupancy  out  $clog2(STAGES+1)  number of valid stage registers.

Behaviour:
- Reset (rst=0, asynchronous):
  - All stage valids cleared; out_valid=0, out_data=0, occupancy=0.
  - in_ready=1 once rst deasserts.
  - All configuration set to sel[s][l]=l, op[s][l]=PASS, i.e. the identity pipeline.
- Stage s combinational path. Input vector x is in_data for s=0, otherwise stage register s-1.
  - Permutation: p[l] = x[sel[s][l]].
  - Filter: r[l] = f(op[s][l], a=p[l], b=p[l^1]).
  - r is loaded into stage register s when the stage advances.
- Opcodes:
  - 0 PASS: a
  - 1 AND: a&b
  - 2 OR: a|b
  - 3 XOR: a^b
  - 4 ANDN: a&~b
  - 5 ZERO: all 0
  - 6 ONES: all 1
  - 7 NOT: ~a
- Flow control:
  - ready[STAGES] = out_ready.
  - ready[s] = !v[s] | ready[s+1].
  - in_ready = ready[0] & !flush.
  - Stage s loads when ready[s] is high. Its new valid is in_valid&in_ready for s=0, otherwise v[s-1].
  - Ready is a combinational chain across all stages.
  - out_data/out_valid are the last stage register.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready is held 1. Throughput is 1 beat per cycle.
- Bubble collapsing: an empty stage loads even if downstream is stalled.
- Ordering: beats never reorder, drop or duplicate.
- out_data holds stable while out_valid=1 and out_ready=0.
- Configuration writes:
  - A write in cycle t takes effect for data latched into that stage from cycle t+1.
  - Beats already in flight are not rewritten.
  - Writes are accepted regardless of flow-control state.
  - A write with cfg_stage >= STAGES is ignored.
- flush=1:
  - All valids clear next edge and occupancy becomes 0.
  - No input is accepted that cycle.
  - Configuration is retained.
  - If cfg_we and flush occur together, both take effect.
- occupancy: registered count of valid stage registers. It is updated every edge and never exceeds STAGES.
- Reset asserted mid-stream: all in-flight beats are discarded and configuration returns to identity.

Test Plan:
- Bench parameters for all scenarios: LANES=4, STAGES=3, BIT_VEC_SIZE=8.
- Identity: after reset, inject lanes {0x0F,0xF0,0xAA,0x55} with out_ready=1 -> same values appear on out_data exactly 3 cycles later.
- Pairwise op: write stage0 lane0 op=AND and lane2 op=XOR; inject {0x0F,0xF0,0xAA,0x55} -> out {0x00,0xF0,0xFF,0x55}.
- Permutation: write stage1 sel lane0=1 and lane1=0; inject {0x11,0x22,0x33,0x44} -> out {0x22,0x11,0x33,0x44}.
- Backpressure: stream beats 1..10 in lane0 continuously, out_ready=0 for cycles 4-8 ->
  - occupancy reaches 3 and in_ready=0 while full;
  - out_data stays stable while stalled;
  - all 10 beats emerge in order with none lost.
- Bubble collapse: send beats every other cycle, then out_ready=0 for 4 cycles -> occupancy reaches 3 and beats arrive in order after release.
- Flush and reset: with 3 beats in flight, flush=1 for one cycle -> occupancy=0, no out_valid afterwards, custom config still active on the next beat.
  - Then rst=0 mid-stream -> outputs clear immediately and config returns to identity.
